reg_frame_mgr: RTL and testbench
================================

REG_FRAME_MGR -- requirements
Module: reg_frame_mgr

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register word width.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning register address width (2^ADDR_W registers).
REQ-003 SHALL have parameter CR_ADDR, default 57, meaning the register selected on read port 1 when use_cr=1.
REQ-004 SHALL have parameters IO_IN_ADDR, default 15, and IO_OUT_ADDR, default 16, meaning the memory-mapped input and output register addresses.
REQ-005 SHALL have parameters FREG_BASE, default 0, and NUM_FREGS, default 15, meaning the first address and size of the saved-frame window.
REQ-006 SHALL have parameter FRAME_DEPTH, default 4, meaning the number of frames the save stack holds.
REQ-007 SHALL use one clock with synchronous, active-high reset.
REQ-008 SHALL have port clk, input, 1, meaning the rising-edge clock.
REQ-009 SHALL have port reset, input, 1, meaning the synchronous active-high reset.
REQ-010 SHALL have ports rd_addr1 and rd_addr2, input, ADDR_W, meaning read addresses.
REQ-011 SHALL have port use_cr, input, 1, meaning read port 1 reads CR_ADDR instead of rd_addr1.
REQ-012 SHALL have ports wr_en1/wr_en2 (input, 1), wr_addr1/wr_addr2 (input, ADDR_W) and wr_data1/wr_data2 (input, DATA_W), meaning two write ports.
REQ-013 SHALL have ports rd_data1 and rd_data2, output, DATA_W, meaning read data.
REQ-014 SHALL have ports io_in (input, DATA_W) and io_out (output, DATA_W), meaning external I/O values.
REQ-015 SHALL have ports cmp_eq and cmp_ne (input, 1) and cmp_result (output, 1), meaning the compare mode and its result.
REQ-016 SHALL have ports save_req and restore_req, input, 1, meaning frame save and restore requests.
REQ-017 SHALL have ports busy, done and err, output, 1, meaning sequencer busy, 1-cycle completion pulse and 1-cycle rejected-request pulse.
REQ-018 SHALL have port frame_count, output, $clog2(FRAME_DEPTH+1), meaning the number of frames stored.

Function
REQ-019 Reads SHALL be combinational from current contents, with no write bypass; an address equal to IO_IN_ADDR SHALL return io_in.
REQ-020 Writes SHALL occur on the rising clock edge when enabled; equal wr_addr1 and wr_addr2 with both enabled SHALL store wr_data2; writes to IO_IN_ADDR SHALL be ignored.
REQ-021 io_out SHALL continuously equal the register at IO_OUT_ADDR.
REQ-022 cmp_result SHALL equal (cmp_eq & rd_data1==rd_data2) | (cmp_ne & rd_data1!=rd_data2); neither mode asserted SHALL give 0.
REQ-023 The sequencer SHALL have states IDLE, SAVE, RESTORE and DONE; busy SHALL be 1 exactly in SAVE and RESTORE.
REQ-024 In IDLE, save_req SHALL enter SAVE if frame_count<FRAME_DEPTH, else pulse err for 1 cycle and stay IDLE.
REQ-025 In IDLE, restore_req SHALL enter RESTORE if frame_count>0, else pulse err for 1 cycle and stay IDLE.
REQ-026 When save_req and restore_req are both asserted in IDLE, save SHALL take priority and restore SHALL be dropped.
REQ-027 In SAVE, index i=0..NUM_FREGS-1 SHALL copy reg[FREG_BASE+i] to stack[frame_count][i], one index per cycle; after the last index frame_count SHALL increment and the state SHALL go to DONE.
REQ-028 In RESTORE, index i SHALL copy stack[frame_count-1][i] to reg[FREG_BASE+i], one per cycle; after the last index frame_count SHALL decrement and the state SHALL go to DONE.
REQ-029 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-030 Latency: a request sampled at edge N SHALL give busy=1 for edges N+1..N+NUM_FREGS and done=1 in the following cycle.
REQ-031 Requests arriving while the sequencer is not in IDLE SHALL be ignored without an err pulse.
REQ-032 During RESTORE, the sequencer write SHALL override any external write to the same address; external writes elsewhere SHALL proceed.
REQ-033 During SAVE, each index SHALL capture the register value present at that index's copy cycle.

Reset
REQ-034 Reset SHALL clear all registers, io_out, busy, done, err, cmp_result-driving state and frame_count to 0, and SHALL force the state to IDLE, including mid-SAVE or mid-RESTORE.
REQ-035 Stack contents SHALL be left uncleared by reset.

Verification
REQ-036 Write reg[a]=a for all a, use_cr=0, read rs/rt -> rd_data=rs/rt, except address 15, which SHALL return io_in.
REQ-037 use_cr=1, rd_addr1=3 -> rd_data1=57; both write ports targeting address 20 with data 5 and 9 -> reg[20]=9.
REQ-038 Fill regs 0-14 with 0..14, save, overwrite with 99, restore -> regs 0-14 = 0..14; busy high 15 cycles; done pulses once; frame_count goes 1 then 0.
REQ-039 Perform 4 saves, then a 5th save -> err pulses 1 cycle and frame_count stays 4; with frame_count=0, restore -> err pulses.
REQ-040 Assert reset at the 7th cycle of a SAVE -> next cycle busy=0, frame_count=0, rd_data=0 everywhere.
REQ-041 Write IO_OUT_ADDR=0x1234 -> io_out=0x1234; with rd_data1=rd_data2, cmp_eq=1 -> cmp_result=1 and cmp_ne=1 -> 0.

Source files
------------

// File: rtl/reg_frame_mgr.sv
// Register file with two write ports and two read ports. It also provides
// memory-mapped I/O registers, an equality/inequality comparator, and a
// sequencer that saves and restores a window of registers to and from a
// small frame stack.
module reg_frame_mgr #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int CR_ADDR     = 57,
  parameter int IO_IN_ADDR  = 15,
  parameter int IO_OUT_ADDR = 16,
  parameter int FREG_BASE   = 0,
  parameter int NUM_FREGS   = 15,
  parameter int FRAME_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_W-1:0]                  rd_addr1,
  input  logic [ADDR_W-1:0]                  rd_addr2,
  input  logic                               use_cr,
  input  logic                               wr_en1,
  input  logic [ADDR_W-1:0]                  wr_addr1,
  input  logic [DATA_W-1:0]                  wr_data1,
  input  logic                               wr_en2,
  input  logic [ADDR_W-1:0]                  wr_addr2,
  input  logic [DATA_W-1:0]                  wr_data2,
  output logic [DATA_W-1:0]                  rd_data1,
  output logic [DATA_W-1:0]                  rd_data2,
  input  logic [DATA_W-1:0]                  io_in,
  output logic [DATA_W-1:0]                  io_out,
  input  logic                               cmp_eq,
  input  logic                               cmp_ne,
  output logic                               cmp_result,
  input  logic                               save_req,
  input  logic                               restore_req,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(FRAME_DEPTH+1)-1:0]   frame_count
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int FC_W     = $clog2(FRAME_DEPTH+1);
  localparam int IDX_W    = (NUM_FREGS > 1) ? $clog2(NUM_FREGS) : 1;
  localparam int SLOT_W   = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              state_r, state_nx_s;
  logic [IDX_W-1:0]    idx_r, idx_nx_s;
  logic [FC_W-1:0]     fc_r, fc_nx_s, fc_m1_s;
  logic                busy_r, done_r, err_r, err_s;
  logic                save_step_s, restore_step_s, idx_last_s;
  logic [ADDR_W-1:0]   freg_addr_s, rd_sel1_s;
  logic [SLOT_W-1:0]   save_slot_s, rest_slot_s;
  logic                data_eq_s;

  logic [DATA_W-1:0]   regs_r  [NUM_REGS];
  logic [DATA_W-1:0]   stack_r [FRAME_DEPTH][NUM_FREGS];

  // Address and slot arithmetic shared by the sequencer and the datapath.
  // A save fills the slot at fc_r; a restore drains the slot at fc_r-1.
  always_comb begin
    freg_addr_s = ADDR_W'(FREG_BASE) + ADDR_W'(idx_r);
    fc_m1_s     = fc_r - FC_W'(1);
    save_slot_s = fc_r[SLOT_W-1:0];
    rest_slot_s = fc_m1_s[SLOT_W-1:0];
    idx_last_s  = (idx_r == IDX_W'(NUM_FREGS-1));
  end

  // Sequencer next-state logic. In IDLE, a save request takes priority
  // over a restore request.
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    fc_nx_s        = fc_r;
    err_s          = 1'b0;
    save_step_s    = 1'b0;
    restore_step_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idx_nx_s = {IDX_W{1'b0}};
        if (save_req) begin
          if (fc_r < FC_W'(FRAME_DEPTH)) begin
            state_nx_s = ST_SAVE;
          end else begin
            err_s = 1'b1;
          end
        end else if (restore_req) begin
          if (fc_r != {FC_W{1'b0}}) begin
            state_nx_s = ST_RESTORE;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SAVE: begin
        save_step_s = 1'b1;
        if (idx_last_s) begin
          fc_nx_s    = fc_r + FC_W'(1);
          idx_nx_s   = {IDX_W{1'b0}};
          state_nx_s = ST_DONE;
        end else begin
          idx_nx_s = idx_r + IDX_W'(1);
        end
      end
      ST_RESTORE: begin
        restore_step_s = 1'b1;
        if (idx_last_s) begin
          fc_nx_s    = fc_m1_s;
          idx_nx_s   = {IDX_W{1'b0}};
          state_nx_s = ST_DONE;
        end else begin
          idx_nx_s = idx_r + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register. The status flags are registered from the
  // next-state value, so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      fc_r    <= {FC_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      fc_r    <= fc_nx_s;
      busy_r  <= (state_nx_s == ST_SAVE) || (state_nx_s == ST_RESTORE);
      done_r  <= (state_nx_s == ST_DONE);
      err_r   <= err_s;
    end
  end

  // Register file write. Port 2 is applied after port 1, so port 2 wins on
  // an address collision. A restore copy is applied last, so it overrides
  // any external write to the same address. The input register is read-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[ADDR_W'(i)] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wr_en1 && (wr_addr1 != ADDR_W'(IO_IN_ADDR))) begin
        regs_r[wr_addr1] <= wr_data1;
      end
      if (wr_en2 && (wr_addr2 != ADDR_W'(IO_IN_ADDR))) begin
        regs_r[wr_addr2] <= wr_data2;
      end
      if (restore_step_s && (freg_addr_s != ADDR_W'(IO_IN_ADDR))) begin
        regs_r[freg_addr_s] <= stack_r[rest_slot_s][idx_r];
      end
    end
  end

  // Frame stack capture. Each index samples the register's value in its own
  // copy cycle. The stack is not cleared on reset.
  always_ff @(posedge clk) begin
    if (save_step_s && !reset) begin
      stack_r[save_slot_s][idx_r] <= regs_r[freg_addr_s];
    end
  end

  // Combinational read ports with no write bypass. The input address
  // returns io_in instead of register contents.
  always_comb begin
    rd_sel1_s = use_cr ? ADDR_W'(CR_ADDR) : rd_addr1;
    if (rd_sel1_s == ADDR_W'(IO_IN_ADDR)) begin
      rd_data1 = io_in;
    end else begin
      rd_data1 = regs_r[rd_sel1_s];
    end
    if (rd_addr2 == ADDR_W'(IO_IN_ADDR)) begin
      rd_data2 = io_in;
    end else begin
      rd_data2 = regs_r[rd_addr2];
    end
  end

  // Comparator over the two read ports. With no mode selected, the result is 0.
  always_comb begin
    data_eq_s  = (rd_data1 == rd_data2);
    cmp_result = (cmp_eq & data_eq_s) | (cmp_ne & ~data_eq_s);
  end

  assign io_out      = regs_r[ADDR_W'(IO_OUT_ADDR)];
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign frame_count = fc_r;

endmodule

// File: tb/tb_reg_frame_mgr.sv
// Directed testbench for reg_frame_mgr with default parameters.
module tb_reg_frame_mgr;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  rd_addr1, rd_addr2, wr_addr1, wr_addr2;
  logic        use_cr, wr_en1, wr_en2;
  logic [15:0] wr_data1, wr_data2, rd_data1, rd_data2, io_in, io_out;
  logic        cmp_eq, cmp_ne, cmp_result;
  logic        save_req, restore_req, busy, done, err;
  logic [2:0]  frame_count;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] IO_IN_V = 16'hBEEF;

  reg_frame_mgr dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .use_cr(use_cr),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .io_in(io_in), .io_out(io_out),
    .cmp_eq(cmp_eq), .cmp_ne(cmp_ne), .cmp_result(cmp_result),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done), .err(err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write1(input int a, input int d);
    wr_en1 = 1'b1; wr_addr1 = 6'(a); wr_data1 = 16'(d);
    cycle();
    wr_en1 = 1'b0;
  endtask

  // Issues one request, then counts busy and done cycles over a bounded window.
  task automatic run_seq(input logic is_save, input string tag);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    save_req = is_save; restore_req = ~is_save;
    cycle();
    save_req = 1'b0; restore_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      cycle();
    end
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd15);
    check({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    check({tag, "_done_at"}, 32'(done_at), 32'd15);
  endtask

  initial begin
    reset = 1'b1; use_cr = 1'b0;
    rd_addr1 = 6'd0; rd_addr2 = 6'd0;
    wr_en1 = 1'b0; wr_en2 = 1'b0;
    wr_addr1 = 6'd0; wr_addr2 = 6'd0; wr_data1 = 16'd0; wr_data2 = 16'd0;
    io_in = IO_IN_V; cmp_eq = 1'b0; cmp_ne = 1'b0;
    save_req = 1'b0; restore_req = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
    rd_addr1 = 6'd5;
    #1;
    check("rst_fc", 32'(frame_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_rd5", 32'(rd_data1), 32'd0);

    // reg[a] = a via both write ports
    for (int a = 0; a < 64; a += 2) begin
      wr_en1 = 1'b1; wr_addr1 = 6'(a);     wr_data1 = 16'(a);
      wr_en2 = 1'b1; wr_addr2 = 6'(a + 1); wr_data2 = 16'(a + 1);
      cycle();
    end
    wr_en1 = 1'b0; wr_en2 = 1'b0;
    for (int a = 0; a < 64; a++) begin
      rd_addr1 = 6'(a); rd_addr2 = 6'(63 - a);
      #1;
      check("rd1", 32'(rd_data1), (a == 15) ? 32'(IO_IN_V) : 32'(a));
      check("rd2", 32'(rd_data2), ((63 - a) == 15) ? 32'(IO_IN_V) : 32'(63 - a));
    end
    check("io_out_16", 32'(io_out), 32'd16);

    // control-register selection on port 1
    use_cr = 1'b1; rd_addr1 = 6'd3;
    #1;
    check("use_cr", 32'(rd_data1), 32'd57);
    use_cr = 1'b0;

    // write-port collision: port 2 wins
    wr_en1 = 1'b1; wr_addr1 = 6'd20; wr_data1 = 16'd5;
    wr_en2 = 1'b1; wr_addr2 = 6'd20; wr_data2 = 16'd9;
    cycle();
    wr_en1 = 1'b0; wr_en2 = 1'b0;
    rd_addr1 = 6'd20;
    #1;
    check("collide", 32'(rd_data1), 32'd9);

    // the input register is not writable
    write1(15, 16'h7777);
    rd_addr1 = 6'd15; io_in = 16'h0101;
    #1;
    check("io_in_rd", 32'(rd_data1), 32'h0101);
    io_in = IO_IN_V;

    // io_out and the comparator
    write1(16, 16'h1234);
    check("io_out", 32'(io_out), 32'h1234);
    rd_addr1 = 6'd20; rd_addr2 = 6'd20;
    cmp_eq = 1'b1; cmp_ne = 1'b0; #1;
    check("cmp_eq_same", 32'(cmp_result), 32'd1);
    cmp_eq = 1'b0; cmp_ne = 1'b1; #1;
    check("cmp_ne_same", 32'(cmp_result), 32'd0);
    rd_addr2 = 6'd21; #1;
    check("cmp_ne_diff", 32'(cmp_result), 32'd1);
    cmp_eq = 1'b1; cmp_ne = 1'b0; #1;
    check("cmp_eq_diff", 32'(cmp_result), 32'd0);
    cmp_eq = 1'b0; rd_addr2 = 6'd20; #1;
    check("cmp_none", 32'(cmp_result), 32'd0);

    // save, clobber, restore
    run_seq(1'b1, "save");
    check("fc_after_save", 32'(frame_count), 32'd1);
    for (int a = 0; a < 15; a++) write1(a, 99);
    rd_addr1 = 6'd7; #1;
    check("clobber", 32'(rd_data1), 32'd99);
    run_seq(1'b0, "restore");
    check("fc_after_restore", 32'(frame_count), 32'd0);
    for (int a = 0; a < 15; a++) begin
      rd_addr1 = 6'(a); #1;
      check("restored", 32'(rd_data1), 32'(a));
    end

    // overflow
    for (int n = 0; n < 4; n++) run_seq(1'b1, "fill");
    check("fc_full", 32'(frame_count), 32'd4);
    save_req = 1'b1; cycle(); save_req = 1'b0;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_busy", 32'(busy), 32'd0);
    cycle();
    check("ovf_err_clr", 32'(err), 32'd0);
    check("ovf_fc", 32'(frame_count), 32'd4);
    for (int n = 0; n < 4; n++) run_seq(1'b0, "drain");
    check("fc_drained", 32'(frame_count), 32'd0);

    // underflow
    restore_req = 1'b1; cycle(); restore_req = 1'b0;
    check("udf_err", 32'(err), 32'd1);
    cycle();
    check("udf_err_clr", 32'(err), 32'd0);

    // simultaneous requests: save wins; a request while busy is ignored
    save_req = 1'b1; restore_req = 1'b1; cycle();
    save_req = 1'b0; restore_req = 1'b0;
    check("prio_busy", 32'(busy), 32'd1);
    check("prio_err", 32'(err), 32'd0);
    restore_req = 1'b1; cycle(); restore_req = 1'b0;
    check("busy_ign_err", 32'(err), 32'd0);
    begin
      int waited;
      waited = 0;
      while (!done && waited < 40) begin
        cycle();
        waited++;
      end
      check("prio_done_seen", 32'(done), 32'd1);
    end
    cycle();
    check("prio_fc", 32'(frame_count), 32'd1);

    // reset during the 7th cycle of a save
    save_req = 1'b1; cycle(); save_req = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("mid_save_busy", 32'(busy), 32'd1);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_fc", 32'(frame_count), 32'd0);
    check("mid_rst_io_out", 32'(io_out), 32'd0);
    for (int a = 0; a < 64; a++) begin
      rd_addr1 = 6'(a); rd_addr2 = 6'(a); #1;
      check("mid_rst_rd1", 32'(rd_data1), (a == 15) ? 32'(IO_IN_V) : 32'd0);
      check("mid_rst_rd2", 32'(rd_data2), (a == 15) ? 32'(IO_IN_V) : 32'd0);
    end
    cycle();
    check("post_rst_done", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
